// File: rtl/multi_blinker_pkg.sv
// Shared mode encoding for the multi-channel blinker.
package multi_blinker_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ON     = 2'd2,
    MODE_STROBE = 2'd3
  } mode_e;

  function automatic logic is_counting(input mode_e m);
    return (m == MODE_BLINK) || (m == MODE_STROBE);
  endfunction

endpackage

// File: rtl/multi_blinker_channel.sv
// One blinker channel: active/shadow (half, mode) pairs, counter, pending flag
// and registered out/tick.
module blink_channel
  import multi_blinker_pkg::*;
#(
  parameter int          CNT_W      = 24,
  parameter int unsigned RESET_HALF = 12500000,
  parameter mode_e       RESET_MODE = MODE_BLINK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_half,
  input  mode_e            wr_mode,
  input  logic             sync,
  output logic             pending,
  output logic             out,
  output logic             tick
);

  logic [CNT_W-1:0] half_q, half_d, cnt_q, cnt_d, sh_half_q, sh_half_d;
  mode_e            mode_q, mode_d, sh_mode_q, sh_mode_d;
  logic             pend_q, pend_d, out_q, out_d, tick_q, tick_d;
  logic [CNT_W-1:0] h_eff, term;

  // A half-period of 0 behaves as 1, so the terminal count never underflows.
  assign h_eff = (half_q == '0) ? CNT_W'(1) : half_q;
  assign term  = h_eff - CNT_W'(1);

  always_comb begin
    half_d    = half_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    sh_half_d = sh_half_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;
    out_d     = out_q;
    tick_d    = 1'b0;

    // wr_en only arrives while not pending, so the shadow is never
    // overwritten under a pending apply.
    if (wr_en) begin
      sh_half_d = wr_half;
      sh_mode_d = wr_mode;
      pend_d    = 1'b1;
    end

    if (sync) begin
      if (pend_d) begin
        half_d = sh_half_d;
        mode_d = sh_mode_d;
      end
      pend_d = 1'b0;
      cnt_d  = '0;
      out_d  = (mode_d == MODE_ON);
    end else if (!is_counting(mode_q)) begin
      cnt_d = '0;
      if (pend_q) begin
        half_d = sh_half_q;
        mode_d = sh_mode_q;
        pend_d = 1'b0;
      end
      out_d = (mode_d == MODE_ON);
    end else if (cnt_q == term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (pend_q) begin
        half_d = sh_half_q;
        mode_d = sh_mode_q;
        pend_d = 1'b0;
        out_d  = (sh_mode_q == MODE_ON);
      end else begin
        out_d = (mode_q == MODE_BLINK) ? ~out_q : 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (mode_q == MODE_STROBE) out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q    <= CNT_W'(RESET_HALF);
      mode_q    <= RESET_MODE;
      cnt_q     <= '0;
      sh_half_q <= CNT_W'(RESET_HALF);
      sh_mode_q <= RESET_MODE;
      pend_q    <= 1'b0;
      out_q     <= (RESET_MODE == MODE_ON);
      tick_q    <= 1'b0;
    end else begin
      half_q    <= half_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      sh_half_q <= sh_half_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
    end
  end

  assign pending = pend_q;
  assign out     = out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/multi_blinker.sv
// Multi-channel programmable blinker / clock divider: write decode, sync
// fan-out and ready mux around an array of blink_channel instances.
module multi_blinker
  import multi_blinker_pkg::*;
#(
  parameter int                CHANNELS   = 4,
  parameter int                CNT_W      = 24,
  parameter int unsigned       RESET_HALF = 12500000,
  parameter logic [MODE_W-1:0] RESET_MODE = 2'd1,
  localparam int               CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Wr_En,
  input  logic [CH_W-1:0]     i_Wr_Ch,
  input  logic [CNT_W-1:0]    i_Wr_Half,
  input  logic [MODE_W-1:0]   i_Wr_Mode,
  input  logic                i_Sync,
  output logic                o_Wr_Ready,
  output logic [CHANNELS-1:0] o_Out,
  output logic [CHANNELS-1:0] o_Tick
);

  logic [CHANNELS-1:0] pending, wr_sel;

  // Out-of-range channel indices never match, so they read as ready.
  always_comb begin
    o_Wr_Ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++)
      if (int'(i_Wr_Ch) == c) o_Wr_Ready = !pending[c];
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign wr_sel[g] = i_Wr_En && o_Wr_Ready && (int'(i_Wr_Ch) == g);

    blink_channel #(
      .CNT_W      (CNT_W),
      .RESET_HALF (RESET_HALF),
      .RESET_MODE (mode_e'(RESET_MODE))
    ) u_ch (
      .clk     (i_Clk),
      .rst_n   (i_Rst_n),
      .wr_en   (wr_sel[g]),
      .wr_half (i_Wr_Half),
      .wr_mode (mode_e'(i_Wr_Mode)),
      .sync    (i_Sync),
      .pending (pending[g]),
      .out     (o_Out[g]),
      .tick    (o_Tick[g])
    );
  end

endmodule

// File: doc/multi_blinker.md
# multi_blinker

Multi-channel, runtime-programmable clock divider and LED pattern generator: the parametrised successor to the fixed-rate divider. Each of CHANNELS outputs has its own half-period and mode, reloadable while running without glitches. A shared sync input phase-aligns all channels. It sits between board-level control logic or a register interface and the LED or slow-clock pins.

## Interface
- CHANNELS, 4, number of independent output channels (1..16)
- CNT_W, 24, counter and half-period width in bits
- RESET_HALF, 12500000, half-period loaded into every channel at reset (1 Hz at 25 MHz)
- RESET_MODE, 2'd1, mode loaded into every channel at reset (BLINK)

- i_Clk  in  1  system clock (25 MHz on the Go Board)
- i_Rst_n  in  1  asynchronous, active-low reset
- i_Wr_En  in  1  write request
- i_Wr_Ch  in  max(1,$clog2(CHANNELS))  target channel; values ≥ CHANNELS are ignored (write dropped, no pending)
- i_Wr_Half  in  CNT_W  new half-period in cycles; 0 is treated as 1
- i_Wr_Mode  in  2  new mode
- i_Sync  in  1  one-cycle pulse to restart all channels in phase
- o_Wr_Ready  out  1  write accepted when i_Wr_En && o_Wr_Ready
- o_Out  out  CHANNELS  channel outputs
- o_Tick  out  CHANNELS  one-cycle pulse at each channel terminal count

## Operation
- Modes: 0 OFF (out 0, counter held 0), 1 BLINK (square wave, period 2·H), 2 ON (out 1, counter held 0), 3 STROBE (out high for one cycle every H cycles).
- Per channel, the block holds an active pair (H, M), a counter (CNT_W bits), a shadow pair, and a pending flag.
- Counting (BLINK and STROBE only): the counter runs 0..H−1. At H−1 it wraps to 0, o_Tick pulses, BLINK toggles out, and STROBE drives out high for that one cycle.
- Write handshake:
  - o_Wr_Ready = !pending[i_Wr_Ch] (combinational). It is 1 for out-of-range channels.
  - An accepted write loads the shadow pair and sets pending.
- Applying a pending write:
  - Active M ∈ {OFF, ON}: the shadow is applied on the next clock edge.
  - Active M ∈ {BLINK, STROBE}: the shadow is applied at the wrap edge (counter H−1 → 0). Out restarts at 0, and the new period counts from that edge.
  - Applying a write clears pending.
- A write accepted on the same cycle as that channel's wrap does not apply at that wrap. It waits for the next wrap.
- i_Sync: on the next edge every counter goes to 0 and every out goes to 0 (ON channels stay 1). Every pending shadow, including a write accepted in the same cycle, is applied and pending is cleared. No o_Tick is produced by sync.
- Width rule: comparisons use max(H,1). H fits CNT_W by construction, so there is no overflow.

## Timing
- Reset values:
  - counters 0, o_Out 0 (1 for channels whose RESET_MODE is ON), o_Tick 0, pending 0, o_Wr_Ready 1
  - active H = RESET_HALF, active M = RESET_MODE
- After reset release, the first BLINK toggle happens on the H-th rising edge.
- o_Out and o_Tick are registered. o_Tick is high on the cycle the counter shows 0 after a wrap, aligned with the toggled out.
- Write latency:
  - From OFF/ON: 1 cycle.
  - From BLINK/STROBE: up to H cycles (until the next wrap).
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Pending writes are lost.

## Structure
- Shared package/include holds the mode constants MODE_OFF, MODE_BLINK, MODE_ON, MODE_STROBE and the 2-bit mode width.
- Sub-module blink_channel contains the counter, active pair, shadow pair and pending flag for one channel.
- The top level generates CHANNELS instances, decodes i_Wr_Ch into per-channel write enables, fans out i_Sync, and muxes pending into o_Wr_Ready.

## Test plan
- Reset, CNT_W=8, RESET_HALF=3, BLINK, release reset → o_Out[0] toggles every 3 cycles, o_Tick[0] pulses every 3 cycles, o_Wr_Ready=1.
- Running H=3, write ch0 H=5 mid-count → o_Wr_Ready low for that channel until the next wrap. After the wrap, toggles occur every 5 cycles.
- Ch1 OFF, write ch1 H=2 mode STROBE → applied next cycle. o_Out[1] is then high 1 cycle in every 2.
- Write H=0 BLINK → out toggles every cycle. Write to channel index 7 with CHANNELS=4 → no state change anywhere.
- Channels at H=3, 4, 5 free-running, pulse i_Sync together with a write ch2 H=6 → all counters 0 and outs 0 next cycle. Ch2 toggles first at 6 cycles, the others at 3 and 4.
- Drop i_Rst_n low for one cycle mid-count with a write pending → outputs at reset values, pending cleared, o_Wr_Ready=1.
